seq_detector_1011_moore_core: RTL and testbench
===============================================

SEQ_DETECTOR_1011_MOORE_CORE -- requirements
Module: seq_detector_1011_moore

Interface
REQ-001 The block SHALL have no parameters; all behaviour is fixed except the Configuration macro.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 data_in  input  1  serial bit stream, one bit sampled per rising clk edge.
REQ-005 detected  output  1  high while the FSM is in the "1011 received" state.

Function
REQ-006 The block SHALL be a Moore FSM; detected SHALL be a function of the current state only, never of data_in.
REQ-007 States SHALL be: S0 (no prefix), S1 ("1"), S2 ("10"), S3 ("101"), S4 ("1011" matched), encoded in 3 bits.
REQ-008 Transitions on data_in=0/1: S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S4.
REQ-009 S4 transitions (default, overlapping): data_in=0 -> S2, data_in=1 -> S1.
REQ-010 detected SHALL be 1 exactly when state==S4, otherwise 0.
REQ-011 Latency: detected SHALL rise on the same rising edge that samples the final "1" of 1011 and stay high for exactly one cycle, unless that edge is followed by another completed match.
REQ-012 Back-to-back overlapping stream 1011011 SHALL produce two one-cycle detected pulses, three cycles apart.
REQ-013 Unused state encodings SHALL return to S0 on the next rising edge with detected=0.
REQ-014 State register SHALL update only on rising clk edge while reset=1.

Reset
REQ-015 reset=0 SHALL force state to S0 and detected to 0 immediately, independent of clk.
REQ-016 While reset=0, data_in SHALL be ignored and detected SHALL remain 0.
REQ-017 Reset asserted mid-sequence (e.g. in S3) SHALL discard the partial match; after release, a full 1011 SHALL be required for detection.
REQ-018 First sampling edge after reset release SHALL evaluate data_in from S0.

Configuration
REQ-019 Macro SEQ_DET_NONOVERLAP_EN: when defined, S4 transitions SHALL be data_in=0 -> S0, data_in=1 -> S1 (the matched bits are not reused); when undefined, REQ-009 overlapping transitions apply.
REQ-020 All other states, transitions, outputs and reset behaviour SHALL be identical in both builds.

Verification
REQ-021 Hold reset=0 for 2 cycles with data_in toggling -> detected=0 throughout, state S0.
REQ-022 Release reset, drive 1,0,1,1 -> detected=1 for exactly the cycle after the 4th sampling edge, 0 before.
REQ-023 Drive 1,0,1,1,0,1,1 (default build) -> detected pulses after bits 4 and 7; with SEQ_DET_NONOVERLAP_EN defined -> single pulse after bit 4 only.
REQ-024 Drive 1,1,1,0,1,1 -> one pulse after bit 6; drive 1,0,0,1,0,1,1 -> one pulse after bit 7 only.
REQ-025 Drive 1,0,1 then assert reset=0 between edges, release, drive 1 -> detected stays 0; drive 0,1,1 -> pulse.
REQ-026 Drive 0 for 8 cycles, then 1 for 8 cycles -> detected=0 throughout.

Source files
------------

// File: rtl/seq_detector_1011_moore_core.sv
// Moore FSM that detects the serial pattern 1011 on data_in (overlapping by default).
// Define SEQ_DET_NONOVERLAP_EN so that a completed match is not reused as a new prefix.
module seq_detector_1011_moore_core (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic detected
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = S0;
    detected = 1'b0;
    case (state_q)
      S0: state_d = data_in ? S1 : S0;
      S1: state_d = data_in ? S1 : S2;
      S2: state_d = data_in ? S3 : S0;
      S3: state_d = data_in ? S4 : S2;
      S4: begin
        detected = 1'b1;
`ifdef SEQ_DET_NONOVERLAP_EN
        state_d = data_in ? S1 : S0;
`else
        // Trailing "1" of the match starts the next "1", and "10" overlaps too.
        state_d = data_in ? S1 : S2;
`endif
      end
      // Unused encodings recover to S0 with detected low.
      default: state_d = S0;
    endcase
  end

endmodule

// File: tb/tb_seq_detector_1011_moore_core.sv
// Directed-vector bench for seq_detector_1011_moore_core; expectations follow the
// build flavour selected by SEQ_DET_NONOVERLAP_EN.
module tb_seq_detector_1011_moore_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_in = 1'b0;
  logic detected;

  int n_vec = 0;
  int n_err = 0;

  seq_detector_1011_moore_core dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .detected (detected)
  );

  always #5 clk = ~clk;

  // Drive one bit, let it be sampled, then observe 1 time unit after the edge.
  task automatic step(input logic b, output logic det);
    data_in = b;
    @(posedge clk);
    #1;
    det = detected;
  endtask

  task automatic rst_pulse();
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic det;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(i[0] ? 1'b0 : 1'b1, det);
      n_vec++;
      if (det !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: detected=%b want 0", i, det);
      end
    end
    // Feed a whole 1011 while held in reset; nothing may be remembered.
    for (int i = 0; i < 4; i++) begin
      step((i == 1) ? 1'b0 : 1'b1, det);
      n_vec++;
      if (det !== 1'b0) begin
        n_err++;
        $display("FAIL reset_ignore cyc%0d: detected=%b want 0", i, det);
      end
    end
    reset = 1'b1;
    step(1'b1, det);
    n_vec++;
    if (det !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_edge: detected=%b want 0", det);
    end
  endtask

  task automatic test_basic();
    logic [4:0] bits = 5'b10110;
    logic [4:0] exp  = 5'b00010;
    logic det;
    rst_pulse();
    for (int i = 4; i >= 0; i--) begin
      step(bits[i], det);
      n_vec++;
      if (det !== exp[i]) begin
        n_err++;
        $display("FAIL basic_1011 bit%0d: detected=%b want %b", 4 - i, det, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] bits = 7'b1011011;
`ifdef SEQ_DET_NONOVERLAP_EN
    logic [6:0] exp  = 7'b0001000;
`else
    logic [6:0] exp  = 7'b0001001;
`endif
    logic det;
    rst_pulse();
    for (int i = 6; i >= 0; i--) begin
      step(bits[i], det);
      n_vec++;
      if (det !== exp[i]) begin
        n_err++;
        $display("FAIL back_to_back bit%0d: detected=%b want %b", 6 - i, det, exp[i]);
      end
    end
  endtask

  task automatic test_prefixes();
    logic [5:0] b1 = 6'b111011;
    logic [5:0] e1 = 6'b000001;
    logic [6:0] b2 = 7'b1001011;
    logic [6:0] e2 = 7'b0000001;
    logic det;
    rst_pulse();
    for (int i = 5; i >= 0; i--) begin
      step(b1[i], det);
      n_vec++;
      if (det !== e1[i]) begin
        n_err++;
        $display("FAIL prefix_111011 bit%0d: detected=%b want %b", 5 - i, det, e1[i]);
      end
    end
    rst_pulse();
    for (int i = 6; i >= 0; i--) begin
      step(b2[i], det);
      n_vec++;
      if (det !== e2[i]) begin
        n_err++;
        $display("FAIL prefix_1001011 bit%0d: detected=%b want %b", 6 - i, det, e2[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre  = 3'b101;
    logic [3:0] post = 4'b1011;
    logic [3:0] exp  = 4'b0001;
    logic det;
    rst_pulse();
    for (int i = 2; i >= 0; i--) begin
      step(pre[i], det);
      n_vec++;
      if (det !== 1'b0) begin
        n_err++;
        $display("FAIL mid_prefix bit%0d: detected=%b want 0", 2 - i, det);
      end
    end
    // Partial "101" must be discarded by a reset pulse between edges.
    rst_pulse();
    for (int i = 3; i >= 0; i--) begin
      step(post[i], det);
      n_vec++;
      if (det !== exp[i]) begin
        n_err++;
        $display("FAIL mid_after bit%0d: detected=%b want %b", 3 - i, det, exp[i]);
      end
    end
    // detected is high now; reset must clear it without a clock edge.
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (detected !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear: detected=%b want 0", detected);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_runs();
    logic det;
    rst_pulse();
    for (int i = 0; i < 16; i++) begin
      step((i < 8) ? 1'b0 : 1'b1, det);
      n_vec++;
      if (det !== 1'b0) begin
        n_err++;
        $display("FAIL runs cyc%0d: detected=%b want 0", i, det);
      end
    end
  endtask

  initial begin
    #1;
    n_vec++;
    if (detected !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: detected=%b want 0", detected);
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_prefixes();
    test_reset_mid();
    test_runs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
